// File: rtl/decode_queue.sv
// decode_queue: fetch-side instruction FIFO feeding a one-register RV32I
// decode stage. Raw {pc, instr} pairs are queued. The FIFO head is decoded
// combinationally and captured into the output register whenever that
// register is empty or being consumed.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [CMD_W-1:0] out_cmd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_rs1_en,
  output logic             out_rs2_en,
  output logic             out_rd_we,
  output logic [31:0]      out_imm,
  output logic             out_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Command codes; 0 is reserved for "no command / illegal".
  localparam logic [CMD_W-1:0]
    C_LUI  = CMD_W'(1),  C_AUIPC = CMD_W'(2),  C_JAL  = CMD_W'(3),  C_JALR = CMD_W'(4),
    C_BEQ  = CMD_W'(5),  C_BNE   = CMD_W'(6),  C_BLT  = CMD_W'(7),  C_BGE  = CMD_W'(8),
    C_BLTU = CMD_W'(9),  C_BGEU  = CMD_W'(10), C_LB   = CMD_W'(11), C_LH   = CMD_W'(12),
    C_LW   = CMD_W'(13), C_LBU   = CMD_W'(14), C_LHU  = CMD_W'(15), C_SB   = CMD_W'(16),
    C_SH   = CMD_W'(17), C_SW    = CMD_W'(18), C_ADDI = CMD_W'(19), C_SLTI = CMD_W'(20),
    C_SLTIU= CMD_W'(21), C_XORI  = CMD_W'(22), C_ORI  = CMD_W'(23), C_ANDI = CMD_W'(24),
    C_SLLI = CMD_W'(25), C_SRLI  = CMD_W'(26), C_SRAI = CMD_W'(27), C_ADD  = CMD_W'(28),
    C_SUB  = CMD_W'(29), C_SLL   = CMD_W'(30), C_SLT  = CMD_W'(31), C_SLTU = CMD_W'(32),
    C_XOR  = CMD_W'(33), C_SRL   = CMD_W'(34), C_SRA  = CMD_W'(35), C_OR   = CMD_W'(36),
    C_AND  = CMD_W'(37);

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL  = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR   = 7'b1100011, OP_LD  = 7'b0000011,
                         OP_ST  = 7'b0100011, OP_IMM   = 7'b0010011, OP_REG = 7'b0110011;

  logic [31:0]      r_pc_mem  [DEPTH];
  logic [31:0]      r_ins_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_cnt;

  logic             r_out_valid, r_out_rs1_en, r_out_rs2_en, r_out_rd_we, r_out_illegal;
  logic [31:0]      r_out_pc, r_out_imm;
  logic [CMD_W-1:0] r_out_cmd;
  logic [4:0]       r_out_rs1, r_out_rs2, r_out_rd;

  logic             w_enq, w_deq;
  logic [31:0]      w_ins;
  logic [6:0]       w_op, w_f7;
  logic [2:0]       w_f3;
  logic [CMD_W-1:0] w_cmd;
  logic [4:0]       w_rs1, w_rs2, w_rd;
  logic             w_e1, w_e2, w_we;
  logic [31:0]      w_imm;

  // No same-cycle bypass: a full queue refuses even if the head is leaving.
  assign in_ready = (r_cnt < CW'(DEPTH));
  assign w_enq    = rdy_in & ~flush_in & in_valid & in_ready;
  assign w_deq    = rdy_in & ~flush_in & (r_cnt != '0) & (~r_out_valid | out_ready);

  // FIFO storage is not reset; pointers/count define what is valid.
  always_ff @(posedge clk_in) begin
    if (w_enq) begin
      r_pc_mem[r_wptr]  <= in_pc;
      r_ins_mem[r_wptr] <= in_instr;
    end
  end

  // Pointers and occupancy; flush clears, pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_enq) r_wptr <= r_wptr + 1'b1;
        if (w_deq) r_rptr <= r_rptr + 1'b1;
        case ({w_enq, w_deq})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  assign w_ins = r_ins_mem[r_rptr];
  assign w_op  = w_ins[6:0];
  assign w_f3  = w_ins[14:12];
  assign w_f7  = w_ins[31:25];

  // Decode the FIFO head: pick the command, then fill only the fields that
  // command uses so unused fields and all illegal encodings read as zero.
  always_comb begin
    w_cmd = '0;
    w_rs1 = '0; w_rs2 = '0; w_rd = '0;
    w_e1  = 1'b0; w_e2 = 1'b0; w_we = 1'b0;
    w_imm = '0;
    case (w_op)
      OP_LUI:   w_cmd = C_LUI;
      OP_AUIPC: w_cmd = C_AUIPC;
      OP_JAL:   w_cmd = C_JAL;
      OP_JALR:  if (w_f3 == 3'd0) w_cmd = C_JALR;
      OP_BR:
        case (w_f3)
          3'd0: w_cmd = C_BEQ;  3'd1: w_cmd = C_BNE;
          3'd4: w_cmd = C_BLT;  3'd5: w_cmd = C_BGE;
          3'd6: w_cmd = C_BLTU; 3'd7: w_cmd = C_BGEU;
          default: w_cmd = '0;
        endcase
      OP_LD:
        case (w_f3)
          3'd0: w_cmd = C_LB;  3'd1: w_cmd = C_LH; 3'd2: w_cmd = C_LW;
          3'd4: w_cmd = C_LBU; 3'd5: w_cmd = C_LHU;
          default: w_cmd = '0;
        endcase
      OP_ST:
        case (w_f3)
          3'd0: w_cmd = C_SB; 3'd1: w_cmd = C_SH; 3'd2: w_cmd = C_SW;
          default: w_cmd = '0;
        endcase
      OP_IMM:
        case (w_f3)
          3'd0: w_cmd = C_ADDI;  3'd2: w_cmd = C_SLTI; 3'd3: w_cmd = C_SLTIU;
          3'd4: w_cmd = C_XORI;  3'd6: w_cmd = C_ORI;  3'd7: w_cmd = C_ANDI;
          3'd1: if (w_f7 == 7'h00) w_cmd = C_SLLI;
          default: begin
            if      (w_f7 == 7'h00) w_cmd = C_SRLI;
            else if (w_f7 == 7'h20) w_cmd = C_SRAI;
          end
        endcase
      OP_REG: begin
        if (w_f7 == 7'h00)
          case (w_f3)
            3'd0: w_cmd = C_ADD; 3'd1: w_cmd = C_SLL;  3'd2: w_cmd = C_SLT;
            3'd3: w_cmd = C_SLTU; 3'd4: w_cmd = C_XOR; 3'd5: w_cmd = C_SRL;
            3'd6: w_cmd = C_OR;  default: w_cmd = C_AND;
          endcase
        else if (w_f7 == 7'h20) begin
          if      (w_f3 == 3'd0) w_cmd = C_SUB;
          else if (w_f3 == 3'd5) w_cmd = C_SRA;
        end
      end
      default: w_cmd = '0;
    endcase

    if (w_cmd != '0) begin
      case (w_op)
        OP_LUI, OP_AUIPC: begin
          w_rd = w_ins[11:7]; w_we = 1'b1;
          w_imm = {w_ins[31:12], 12'b0};
        end
        OP_JAL: begin
          w_rd = w_ins[11:7]; w_we = 1'b1;
          w_imm = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
        end
        OP_JALR, OP_LD: begin
          w_rs1 = w_ins[19:15]; w_e1 = 1'b1; w_rd = w_ins[11:7]; w_we = 1'b1;
          w_imm = {{20{w_ins[31]}}, w_ins[31:20]};
        end
        OP_BR: begin
          w_rs1 = w_ins[19:15]; w_e1 = 1'b1; w_rs2 = w_ins[24:20]; w_e2 = 1'b1;
          w_imm = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
        end
        OP_ST: begin
          w_rs1 = w_ins[19:15]; w_e1 = 1'b1; w_rs2 = w_ins[24:20]; w_e2 = 1'b1;
          w_imm = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
        end
        OP_IMM: begin
          w_rs1 = w_ins[19:15]; w_e1 = 1'b1; w_rd = w_ins[11:7]; w_we = 1'b1;
          // Shifts carry a 5-bit unsigned shamt, not a signed immediate.
          if (w_f3 == 3'd1 || w_f3 == 3'd5) w_imm = {27'b0, w_ins[24:20]};
          else                              w_imm = {{20{w_ins[31]}}, w_ins[31:20]};
        end
        default: begin
          w_rs1 = w_ins[19:15]; w_e1 = 1'b1; w_rs2 = w_ins[24:20]; w_e2 = 1'b1;
          w_rd  = w_ins[11:7];  w_we = 1'b1;
        end
      endcase
    end
  end

  // Output stage: load the decoded head when free or being consumed; hold under backpressure.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_out_valid   <= 1'b0;
      r_out_pc      <= '0;
      r_out_cmd     <= '0;
      r_out_rs1     <= '0;
      r_out_rs2     <= '0;
      r_out_rd      <= '0;
      r_out_rs1_en  <= 1'b0;
      r_out_rs2_en  <= 1'b0;
      r_out_rd_we   <= 1'b0;
      r_out_imm     <= '0;
      r_out_illegal <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_out_valid <= 1'b0;
      end else if (w_deq) begin
        r_out_valid   <= 1'b1;
        r_out_pc      <= r_pc_mem[r_rptr];
        r_out_cmd     <= w_cmd;
        r_out_rs1     <= w_rs1;
        r_out_rs2     <= w_rs2;
        r_out_rd      <= w_rd;
        r_out_rs1_en  <= w_e1;
        r_out_rs2_en  <= w_e2;
        r_out_rd_we   <= w_we;
        r_out_imm     <= w_imm;
        r_out_illegal <= (w_cmd == '0);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_cmd     = r_out_cmd;
  assign out_rs1     = r_out_rs1;
  assign out_rs2     = r_out_rs2;
  assign out_rd      = r_out_rd;
  assign out_rs1_en  = r_out_rs1_en;
  assign out_rs2_en  = r_out_rs2_en;
  assign out_rd_we   = r_out_rd_we;
  assign out_imm     = r_out_imm;
  assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: table of hand-decoded instructions fed through the queue,
// expected ops tracked in a scoreboard queue, plus directed sequences for
// latency, backpressure, rdy_in hold, capacity/flush and mid-op reset.
module tb_decode_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  cmd;
    logic [4:0]  rs1, rs2, rd;
    logic        e1, e2, we;
    logic [31:0] imm;
    logic        ill;
  } op_t;

  typedef struct {
    logic [31:0] instr;
    op_t         op;
  } vec_t;

  localparam int NV = 18;

  logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b0, flush_in = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_instr = '0;
  logic        in_ready, out_valid, out_rs1_en, out_rs2_en, out_rd_we, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [5:0]  out_cmd;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  decode_queue #(.DEPTH(4), .CMD_W(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_cmd(out_cmd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_we(out_rd_we),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  always #5 clk_in = ~clk_in;

  int   checks = 0, failures = 0, acc_cnt = 0;
  vec_t vt [NV];
  op_t  sb [$];
  op_t  cur_exp, hold_snap;
  logic acc_now = 1'b0, hold_pend = 1'b0;

  function automatic op_t mk(logic [5:0] c, logic [4:0] s1, logic [4:0] s2, logic [4:0] d,
                             logic e1, logic e2, logic we, logic [31:0] imm, logic ill);
    op_t o;
    o.pc = '0; o.cmd = c; o.rs1 = s1; o.rs2 = s2; o.rd = d;
    o.e1 = e1; o.e2 = e2; o.we = we; o.imm = imm; o.ill = ill;
    return o;
  endfunction

  function automatic op_t act_op();
    op_t o;
    o.pc = out_pc; o.cmd = out_cmd; o.rs1 = out_rs1; o.rs2 = out_rs2; o.rd = out_rd;
    o.e1 = out_rs1_en; o.e2 = out_rs2_en; o.we = out_rd_we; o.imm = out_imm; o.ill = out_illegal;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [95:0] a, input logic [95:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic drive(input int k, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = vt[k].instr;
    in_pc    = pc;
    cur_exp  = vt[k].op;
    cur_exp.pc = pc;
  endtask

  // One clock: sample at negedge (scoreboard pop/push, hold stability), then
  // let the rising edge happen and return 1 time unit after it.
  task automatic step();
    op_t a, e;
    @(negedge clk_in);
    acc_now = 1'b0;
    a = act_op();
    if (hold_pend && out_valid) chk("hold_stable", 96'(a), 96'(hold_snap));
    if (rst_in && rdy_in && flush_in) begin
      sb.delete();
    end else if (rst_in && rdy_in) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_op: got %h expected none", a);
        end else begin
          e = sb.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL op: got %h expected %h", a, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        acc_now = 1'b1;
        acc_cnt++;
      end
    end
    hold_pend = rst_in && out_valid && !out_ready && !(rdy_in && flush_in);
    hold_snap = a;
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < budget && sb.size() > 0; n++) step();
    chk("drain_empty", 96'(sb.size()), 96'(0));
  endtask

  initial begin
    // Expected decodes worked out by hand from the RV32I encodings.
    vt[0]  = '{32'h00500093, mk(6'd19, 5'd0, 5'd0, 5'd1, 1, 0, 1, 32'h00000005, 0)}; // addi x1,x0,5
    vt[1]  = '{32'hFE208EE3, mk(6'd5,  5'd1, 5'd2, 5'd0, 1, 1, 0, 32'hFFFFFFFC, 0)}; // beq x1,x2,-4
    vt[2]  = '{32'h40725193, mk(6'd27, 5'd4, 5'd0, 5'd3, 1, 0, 1, 32'h00000007, 0)}; // srai x3,x4,7
    vt[3]  = '{32'h00000000, mk(6'd0,  5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0,        1)}; // all zero
    vt[4]  = '{32'h123452B7, mk(6'd1,  5'd0, 5'd0, 5'd5, 0, 0, 1, 32'h12345000, 0)}; // lui
    vt[5]  = '{32'h002081B3, mk(6'd28, 5'd1, 5'd2, 5'd3, 1, 1, 1, 32'h0,        0)}; // add
    vt[6]  = '{32'h402081B3, mk(6'd29, 5'd1, 5'd2, 5'd3, 1, 1, 1, 32'h0,        0)}; // sub
    vt[7]  = '{32'h0020A423, mk(6'd18, 5'd1, 5'd2, 5'd0, 1, 1, 0, 32'h00000008, 0)}; // sw x2,8(x1)
    vt[8]  = '{32'hFFC12203, mk(6'd13, 5'd2, 5'd0, 5'd4, 1, 0, 1, 32'hFFFFFFFC, 0)}; // lw x4,-4(x2)
    vt[9]  = '{32'h008000EF, mk(6'd3,  5'd0, 5'd0, 5'd1, 0, 0, 1, 32'h00000008, 0)}; // jal x1,8
    vt[10] = '{32'h01F09093, mk(6'd25, 5'd1, 5'd0, 5'd1, 1, 0, 1, 32'h0000001F, 0)}; // slli x1,x1,31
    vt[11] = '{32'h41F09093, mk(6'd0,  5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0,        1)}; // slli bad funct7
    vt[12] = '{32'hFFFFF117, mk(6'd2,  5'd0, 5'd0, 5'd2, 0, 0, 1, 32'hFFFFF000, 0)}; // auipc
    vt[13] = '{32'h00003003, mk(6'd0,  5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0,        1)}; // load funct3=3
    vt[14] = '{32'h00008067, mk(6'd4,  5'd1, 5'd0, 5'd0, 1, 0, 1, 32'h0,        0)}; // jalr x0,0(x1)
    vt[15] = '{32'h4020D1B3, mk(6'd35, 5'd1, 5'd2, 5'd3, 1, 1, 1, 32'h0,        0)}; // sra
    vt[16] = '{32'h00000073, mk(6'd0,  5'd0, 5'd0, 5'd0, 0, 0, 0, 32'h0,        1)}; // ecall
    vt[17] = '{32'h0030D093, mk(6'd26, 5'd1, 5'd0, 5'd1, 1, 0, 1, 32'h00000003, 0)}; // srli x1,x1,3

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_out_valid", 96'(out_valid), 96'(0));
    chk("rst_out_cmd",   96'(out_cmd),   96'(0));
    chk("rst_out_imm",   96'(out_imm),   96'(0));
    rst_in = 1'b1;
    rdy_in = 1'b1;
    step();
    chk("rst_in_ready",  96'(in_ready),  96'(1));
    chk("rst_valid_post", 96'(out_valid), 96'(0));

    // Latency: accepted at edge N, presented after edge N+1
    out_ready = 1'b1;
    drive(0, 32'h0);
    step();
    in_valid = 1'b0;
    chk("lat_after_N", 96'(out_valid), 96'(0));
    step();
    chk("lat_after_N1", 96'(out_valid), 96'(1));
    drain(10);

    // Table stream back-to-back: one accept per cycle
    for (int k = 0; k < NV; k++) begin
      drive(k, 32'h1000 + 32'(4 * k));
      step();
      chk("b2b_accept", 96'(acc_now), 96'(1));
    end
    drain(20);

    // Same table under random backpressure
    for (int k = 0; k < NV; k++) begin
      drive(k, 32'h2000 + 32'(4 * k));
      out_ready = 1'($urandom_range(0, 1));
      step();
      for (int t = 0; t < 50 && !acc_now; t++) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
      chk("bp_accept", 96'(acc_now), 96'(1));
    end
    drain(40);

    // rdy_in=0 holds everything and ignores flush/in_valid
    out_ready = 1'b0;
    drive(5, 32'h3000); step();
    drive(7, 32'h3004); step();
    in_valid = 1'b0;    step();
    rdy_in = 1'b0; flush_in = 1'b1; out_ready = 1'b1;
    drive(9, 32'h3008);
    repeat (3) step();
    chk("hold_valid",    96'(out_valid), 96'(1));
    chk("hold_pc",       96'(out_pc),    96'(32'h3000));
    chk("hold_in_ready", 96'(in_ready),  96'(1));
    rdy_in = 1'b1; flush_in = 1'b0;
    drain(10);

    // Capacity DEPTH+1 with a stalled consumer, then flush
    acc_cnt   = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(k, 32'h4000 + 32'(4 * k));
      step();
    end
    in_valid = 1'b0;
    chk("cap_accepted", 96'(acc_cnt),  96'(5));
    chk("cap_in_ready", 96'(in_ready), 96'(0));
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    chk("flush_valid",    96'(out_valid), 96'(0));
    chk("flush_in_ready", 96'(in_ready),  96'(1));
    out_ready = 1'b1;
    repeat (6) step();
    chk("flush_no_stale", 96'(out_valid), 96'(0));
    drive(2, 32'h5000);
    step();
    drain(10);

    // Asynchronous reset in the middle of traffic
    out_ready = 1'b0;
    for (int k = 3; k < 6; k++) begin
      drive(k, 32'h6000 + 32'(4 * k));
      step();
    end
    in_valid = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    chk("mid_rst_valid",    96'(out_valid), 96'(0));
    chk("mid_rst_cmd",      96'(out_cmd),   96'(0));
    chk("mid_rst_in_ready", 96'(in_ready),  96'(1));
    sb.delete();
    hold_pend = 1'b0;
    step();
    rst_in = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_valid", 96'(out_valid), 96'(0));
    drive(1, 32'h7000);
    step();
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries between fetch and decode output; power of two, at least 2.
REQ-002 SHALL have parameter CMD_W, default 6, width of the command code.
REQ-003 SHALL have port clk_in, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port rdy_in, input, 1 bit: global enable; when low, all state is held.
REQ-006 SHALL have port flush_in, input, 1 bit: discard all queued and decoded instructions (mispredict).
REQ-007 SHALL have ports in_valid (input, 1), in_pc (input, 32) and in_instr (input, 32): fetch-side instruction offer.
REQ-008 SHALL have port in_ready, output, 1 bit: queue can accept an instruction this cycle.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): decoded-op handshake.
REQ-010 SHALL have port out_pc, output, 32 bits: PC of the decoded op.
REQ-011 SHALL have port out_cmd, output, CMD_W bits: Cmd* code from the team define file; 0 means none.
REQ-012 SHALL have ports out_rs1 / out_rs2 / out_rd, output, 5 bits each: register addresses.
REQ-013 SHALL have ports out_rs1_en / out_rs2_en / out_rd_we, output, 1 bit each: source-read and destination-write flags.
REQ-014 SHALL have port out_imm, output, 32 bits: decoded immediate.
REQ-015 SHALL have port out_illegal, output, 1 bit: unsupported encoding.

Function
REQ-016 Enqueue SHALL occur on an edge where rdy_in=1, flush_in=0, in_valid=1 and in_ready=1.
- in_ready = (count < DEPTH); no same-cycle bypass when full.
REQ-017 The FIFO SHALL use separate read and write pointers that wrap modulo DEPTH.
- count is $clog2(DEPTH)+1 bits.
- Simultaneous enqueue and dequeue leaves count unchanged.
REQ-018 The output stage SHALL be one register.
- It loads the decoded FIFO head when the FIFO is non-empty and (out_valid=0 or out_ready=1).
- A consumed op is replaced by the next one in the same edge.
REQ-019 Latency SHALL be as follows.
- An instruction enqueued at edge N, with the FIFO empty and the output stage free, is presented with out_valid=1 after edge N+1.
- Sustained throughput is 1 op per cycle.
- Total capacity is DEPTH+1.
REQ-020 While out_valid=1 and out_ready=0, all out_* signals SHALL be held stable.
REQ-021 Decode SHALL cover all of RV32I except FENCE/ECALL/EBREAK/CSR.
- LUI/AUIPC: U-imm.
- JAL: J-imm, rd_we=1.
- JALR and loads: I-imm, rs1_en=1, rd_we=1.
- Branches: B-imm, rs1_en=1, rs2_en=1.
- Stores: S-imm, rs1_en=1, rs2_en=1.
- OP-IMM: I-imm, rs1_en=1, rd_we=1.
- OP: rs1_en=1, rs2_en=1, rd_we=1.
REQ-022 Immediates SHALL be sign-extended from instr[31].
- For SLLI/SRLI/SRAI, out_imm = zero-extended instr[24:20].
- SRAI/SRA is selected by instr[30]=1, SRLI/SRL by instr[30]=0.
- ADD/SUB is selected by instr[30].
REQ-023 Unused fields SHALL be driven to 0: out_rs*, out_rd and out_imm when not applicable.
REQ-024 Illegal or unsupported opcodes, funct3 or funct7 values SHALL produce out_cmd=0, all enables 0 and out_illegal=1.
- They still pass through the queue in order.
REQ-025 flush_in=1 with rdy_in=1 SHALL take priority over every other event at that edge.
- Pointers and count are cleared and out_valid is set to 0.
- in_valid is ignored at that edge.
REQ-026 With rdy_in=0, pointers, count and the output stage SHALL hold, and flush_in is ignored.

Reset
REQ-027 While rst_in=0, the following SHALL be cleared asynchronously: pointers, count, out_valid and all out_* registers (to 0).
- in_ready=1 on the first edge after release.
- FIFO storage contents need not be reset.
REQ-028 Reset asserted mid-operation SHALL discard all queued and presented instructions, with no partial op emitted.

Verification
REQ-029 Reset: hold rst_in=0, then release -> out_valid=0, out_cmd=0, out_imm=0, in_ready=1.
REQ-030 in_instr=0x00500093 (addi x1,x0,5), in_pc=0x0 at edge N -> after edge N+1:
- out_valid=1, out_cmd=CmdADDI, out_rd=1, out_rs1=0, out_rs1_en=1, out_rd_we=1, out_imm=0x00000005.
REQ-031 0xFE208EE3 (beq x1,x2,-4) -> CmdBEQ, rs1=1, rs2=2, both rs*_en=1, rd_we=0, imm=0xFFFFFFFC.
REQ-032 0x40725193 (srai x3,x4,7) -> CmdSRAI, imm=0x00000007.
REQ-033 0x00000000 -> out_illegal=1, out_cmd=0.
REQ-034 DEPTH=4, out_ready=0, offer 7 instructions back-to-back:
- exactly 5 are accepted and in_ready=0 afterwards.
- Then pulse flush_in -> next cycle out_valid=0, in_ready=1.
- Subsequent draining yields nothing stale.
